mfp_ahb_lite_timer: RTL and testbench
=====================================

// Module: mfp_ahb_lite_timer
// PURPOSE
//  AHB-Lite slave timer/counter. Attaches to one HSEL output of the AHB-Lite matrix, alongside the RAM, GPIO and UART slaves.
//  Provides a free-running or auto-reload counter with a compare match, an overflow flag and a level interrupt.
//  Zero-wait-state slave with registered address-phase capture.
// PARAMETERS
//  COUNT_WIDTH     32  width of COUNT and COMPARE (1..32); upper read bits are zero
//  PRESCALE_WIDTH  16  width of PRESCALE register and prescale counter
// PORTS
//  HCLK        in   1   bus clock; single clock domain
//  HRESETn     in   1   reset, asynchronous assert, active-low
//  HADDR       in   32  address; only HADDR[4:2] decoded
//  HBURST      in   3   ignored
//  HMASTLOCK   in   1   ignored
//  HPROT       in   4   ignored
//  HSEL        in   1   slave select from the matrix decoder
//  HSIZE       in   3   ignored; all accesses treated as 32-bit
//  HTRANS      in   2   transfer type; HTRANS[1]=1 (NONSEQ/SEQ) is a valid transfer
//  HWDATA      in   32  write data, data phase
//  HWRITE      in   1   1 = write
//  HRDATA      out  32  read data, data phase
//  HREADY      out  1   constant 1; no wait states
//  HRESP       out  1   constant 0 (OKAY)
//  SI_Endian   in   1   ignored
//  TIMER_IRQ   out  1   level interrupt
// BEHAVIOUR
//  Register map (offset from HADDR[4:2]):
//   0x00 CTRL      [0]EN [1]AUTO [2]IE_MATCH [3]IE_OVF; other bits read 0
//   0x04 STATUS    [0]MATCH [1]OVF; write 1 to clear
//   0x08 COUNT
//   0x0C COMPARE
//   0x10 PRESCALE  (see CONFIGURATION)
//   0x14-0x1C read 0; writes ignored
//  Bus pipeline:
//   - Address phase: when HSEL & HTRANS[1], latch addr[4:2], HWRITE and a valid bit on the HCLK edge.
//   - Data phase: a write commits HWDATA on the next edge.
//   - Read: HRDATA is combinational from the latched address. It shows register contents during the data-phase cycle.
//   - HRDATA is 0 when no valid read is latched.
//   - A write followed back-to-back by a read of the same register returns the new value.
//  Tick:
//   - tick=1 every cycle, or per the prescaler.
//   - Counting occurs only when CTRL.EN=1.
//  On a tick with EN=1:
//   - COUNT==COMPARE: set MATCH. If AUTO=1, COUNT<=0; otherwise COUNT<=COUNT+1.
//   - COUNT==all-ones and not reloaded: COUNT<=0 and set OVF.
//   - Both conditions may fire in the same tick; both flags then set.
//  Priorities:
//   - A bus write to COUNT overrides the tick update in the same cycle.
//   - A flag set event beats a W1C clear in the same cycle; the flag stays 1.
//  Enable timing: EN written in data-phase cycle N; the first increment occurs on the edge ending cycle N+1.
//  TIMER_IRQ = (MATCH & IE_MATCH) | (OVF & IE_OVF). Combinational from registered flags; glitch-free.
//  Reset values: CTRL=0, STATUS=0, COUNT=0, COMPARE=all-ones, PRESCALE=0, prescale counter=0, latched valid=0.
//   Outputs at reset: HRDATA=0, TIMER_IRQ=0, HREADY=1, HRESP=0.
//  A reset asserted mid-count clears all state immediately, independent of HCLK.
// CONFIGURATION
//  MFP_TIMER_PRESCALER_EN
//   Defined: PRESCALE register at 0x10 is read/write (PRESCALE_WIDTH bits).
//    - An internal counter counts 0..PRESCALE while EN=1.
//    - tick=1 when the counter equals PRESCALE, then the counter returns to 0. PRESCALE=0 gives a tick every cycle.
//    - Writing PRESCALE or clearing EN resets the counter to 0.
//   Undefined: tick=1 every cycle. Offset 0x10 reads 0 and writes are ignored. No prescale logic.
// TESTING
//  1 Reset -> read regs: CTRL=0, STATUS=0, COUNT=0, COMPARE=0xFFFFFFFF; TIMER_IRQ=0, HREADY=1, HRESP=0 throughout.
//  2 COMPARE=5, then CTRL=0x7 -> COUNT 0..5 then 0, repeating. MATCH=1 and TIMER_IRQ=1 from the edge where COUNT 5->0.
//  3 Write STATUS=0x1 -> MATCH=0 and IRQ drops next cycle. A W1C coincident with a match tick leaves MATCH=1.
//  4 CTRL=0, COUNT=0xFFFFFFFE, COMPARE=0x10, then CTRL=0x9 -> COUNT FFFFFFFF, 0. OVF=1 and IRQ=1; MATCH stays 0.
//  5 Back-to-back NONSEQ: write COMPARE=0x1234, read COMPARE -> 0x1234. Reading 0x18 -> 0. IDLE/HSEL=0 writes change nothing.
//  6 With macro: PRESCALE=3, CTRL=0x1 -> COUNT increments every 4th cycle.
//    Without macro: 0x10 reads 0 after writing 0xFFFF. Async reset mid-count zeroes COUNT.

Source files
------------

// File: rtl/mfp_ahb_lite_timer.sv
// mfp_ahb_lite_timer: zero-wait AHB-Lite timer/counter with compare match, overflow and level IRQ.
// Optional prescaler enabled by defining MFP_TIMER_PRESCALER_EN.
module mfp_ahb_lite_timer #(
  parameter int COUNT_WIDTH    = 32,
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] HADDR,
  input  logic [2:0]  HBURST,
  input  logic        HMASTLOCK,
  input  logic [3:0]  HPROT,
  input  logic        HSEL,
  input  logic [2:0]  HSIZE,
  input  logic [1:0]  HTRANS,
  input  logic [31:0] HWDATA,
  input  logic        HWRITE,
  output logic [31:0] HRDATA,
  output logic        HREADY,
  output logic        HRESP,
  input  logic        SI_Endian,
  output logic        TIMER_IRQ
);
  logic [2:0] addr_q;
  logic write_q, valid_q, we, tick, run, hit, reload;
  logic [3:0] ctrl;
  logic match, ovf, clr_match, clr_ovf;
  logic [COUNT_WIDTH-1:0] count, compare;
  logic [31:0] psc_rd, reg_val;
  logic unused_ok;

  assign unused_ok = ^{HADDR[31:5], HADDR[1:0], HBURST, HMASTLOCK, HPROT, HSIZE, HTRANS[0], SI_Endian};
  assign HREADY = 1'b1;
  assign HRESP = 1'b0;
  assign we = valid_q & write_q;

  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      addr_q  <= HADDR[4:2];
      write_q <= HWRITE;
      valid_q <= HSEL & HTRANS[1];
    end

`ifdef MFP_TIMER_PRESCALER_EN
  logic [PRESCALE_WIDTH-1:0] prescale, psc_cnt;
  logic we_psc;
  assign we_psc = we && addr_q == 3'd4;
  assign tick = psc_cnt == prescale;
  assign psc_rd = 32'(prescale);
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      prescale <= '0;
      psc_cnt  <= '0;
    end else begin
      if (we_psc) prescale <= HWDATA[PRESCALE_WIDTH-1:0];
      psc_cnt <= (!ctrl[0] || we_psc || tick) ? '0 : psc_cnt + 1'b1;
    end
`else
  logic [PRESCALE_WIDTH-1:0] unused_prescale;
  assign unused_prescale = '0;
  assign tick = 1'b1;
  assign psc_rd = '0;
`endif

  assign run = ctrl[0] & tick;
  assign hit = count == compare;
  assign reload = hit & ctrl[1];
  assign clr_match = we && addr_q == 3'd1 && HWDATA[0];
  assign clr_ovf = we && addr_q == 3'd1 && HWDATA[1];

  // Set events win over W1C clears; a COUNT write wins over the tick update.
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      ctrl    <= '0;
      match   <= 1'b0;
      ovf     <= 1'b0;
      count   <= '0;
      compare <= '1;
    end else begin
      if (we && addr_q == 3'd0) ctrl <= HWDATA[3:0];
      if (we && addr_q == 3'd3) compare <= HWDATA[COUNT_WIDTH-1:0];
      match <= (run & hit) | (match & ~clr_match);
      ovf   <= (run & (&count) & ~reload) | (ovf & ~clr_ovf);
      count <= (we && addr_q == 3'd2) ? HWDATA[COUNT_WIDTH-1:0] :
               run ? (reload ? '0 : count + 1'b1) : count;
    end

  assign reg_val = addr_q == 3'd0 ? {28'b0, ctrl} :
                   addr_q == 3'd1 ? {30'b0, ovf, match} :
                   addr_q == 3'd2 ? 32'(count) :
                   addr_q == 3'd3 ? 32'(compare) :
                   addr_q == 3'd4 ? psc_rd : '0;
  assign HRDATA = (valid_q & ~write_q) ? reg_val : '0;
  assign TIMER_IRQ = (match & ctrl[2]) | (ovf & ctrl[3]);
endmodule

// File: tb/tb_mfp_ahb_lite_timer.sv
// tb_mfp_ahb_lite_timer: directed and randomized bus traffic checked against a cycle-level reference model.
module tb_mfp_ahb_lite_timer;
  logic HCLK = 0, HRESETn = 0;
  logic [31:0] HADDR = 0, HWDATA = 0;
  logic [2:0] HBURST = 0, HSIZE = 3'd2;
  logic HMASTLOCK = 0, HSEL = 0, HWRITE = 0, SI_Endian = 0;
  logic [3:0] HPROT = 0;
  logic [1:0] HTRANS = 0;
  logic [31:0] HRDATA;
  logic HREADY, HRESP, TIMER_IRQ;
  int tests = 0, fails = 0;

  localparam longint MAX = 64'hFFFF_FFFF;
  logic [3:0] m_ctrl;
  bit m_match, m_ovf;
  longint m_count, m_compare;
  int m_prescale, m_phase;

  mfp_ahb_lite_timer dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HBURST(HBURST), .HMASTLOCK(HMASTLOCK),
    .HPROT(HPROT), .HSEL(HSEL), .HSIZE(HSIZE), .HTRANS(HTRANS), .HWDATA(HWDATA), .HWRITE(HWRITE),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP), .SI_Endian(SI_Endian), .TIMER_IRQ(TIMER_IRQ)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_ctrl = 0; m_match = 0; m_ovf = 0; m_count = 0; m_compare = MAX; m_prescale = 0; m_phase = 0;
  endtask

  function automatic logic [31:0] m_reg(input int a);
    case (a)
      0: return {28'b0, m_ctrl};
      1: return {30'b0, m_ovf, m_match};
      2: return m_count[31:0];
      3: return m_compare[31:0];
`ifdef MFP_TIMER_PRESCALER_EN
      4: return m_prescale;
`endif
      default: return 0;
    endcase
  endfunction

  // One clock edge; wr says a write data phase for register a commits at this edge.
  task automatic step(input bit wr, input int a, input logic [31:0] d);
    bit en, tick, hit, rl, sm, so;
    longint nc;
    en = m_ctrl[0]; sm = 0; so = 0; nc = m_count;
`ifdef MFP_TIMER_PRESCALER_EN
    tick = (m_phase % (m_prescale + 1)) == m_prescale;
`else
    tick = 1;
`endif
    if (en && tick) begin
      hit = m_count == m_compare;
      rl = hit && m_ctrl[1];
      sm = hit;
      so = (m_count == MAX) && !rl;
      nc = rl ? 0 : (m_count + 1) % (MAX + 1);
    end
    @(posedge HCLK); #1;
    m_phase = (!en || (wr && a == 4)) ? 0 : m_phase + 1;
    m_match = sm || (m_match && !(wr && a == 1 && d[0]));
    m_ovf = so || (m_ovf && !(wr && a == 1 && d[1]));
    m_count = nc;
    if (wr) begin
      if (a == 0) m_ctrl = d[3:0];
      if (a == 2) m_count = d;
      if (a == 3) m_compare = d;
`ifdef MFP_TIMER_PRESCALER_EN
      if (a == 4) m_prescale = d[15:0];
`endif
    end
    check("irq", {31'b0, TIMER_IRQ}, {31'b0, (m_match & m_ctrl[2]) | (m_ovf & m_ctrl[3])});
    check("hready", {31'b0, HREADY}, 1);
    check("hresp", {31'b0, HRESP}, 0);
  endtask

  task automatic addr_phase(input int a, input bit w);
    HSEL = 1; HTRANS = 2'(($urandom & 1) | 2); HWRITE = w;
    HADDR = ($urandom & ~32'h1C) | 32'(a << 2);
  endtask

  task automatic bus_idle();
    HSEL = 0; HTRANS = 0; HWRITE = 0;
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    addr_phase(a, 1); step(0, 0, 0);
    bus_idle(); HWDATA = d; step(1, a, d);
  endtask

  task automatic rd(input int a, input string tag);
    addr_phase(a, 0); step(0, 0, 0);
    bus_idle(); HWDATA = $urandom;
    check(tag, HRDATA, m_reg(a));
  endtask

  task automatic b2b(input int a, input logic [31:0] d);
    addr_phase(a, 1); step(0, 0, 0);
    addr_phase(a, 0); HWDATA = d; step(1, a, d);
    bus_idle();
    check("b2b", HRDATA, m_reg(a));
  endtask

  function automatic logic [31:0] rnd_data(input int a);
    int k = $urandom_range(0, 2);
    case (a)
      1: return $urandom_range(0, 3);
      2, 3: return k == 0 ? $urandom_range(0, 12) : k == 1 ? 32'hFFFF_FFF0 | $urandom_range(0, 15) : $urandom;
      4: return $urandom_range(0, 3);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    m_reset();
    #1;
    check("rst_hrdata", HRDATA, 0);
    check("rst_irq", {31'b0, TIMER_IRQ}, 0);
    check("rst_hready", {31'b0, HREADY}, 1);
    check("rst_hresp", {31'b0, HRESP}, 0);
    #21 HRESETn = 1;

    rd(0, "rst_ctrl"); rd(1, "rst_status"); rd(2, "rst_count"); rd(3, "rst_compare");
    check("rst_compare_const", HRDATA, 32'hFFFF_FFFF);

    wr(3, 5); wr(0, 7);
    repeat (14) rd(2, "auto_count");

    wr(1, 1); rd(1, "w1c_clear");
    begin
      int n = 0;
      while (m_count != 4 && n < 20) begin bus_idle(); step(0, 0, 0); n++; end
      check("w1c_wait", {31'b0, m_count == 4}, 1);
    end
    wr(1, 1); rd(1, "w1c_race");
    check("w1c_race_bit", {31'b0, HRDATA[0]}, 1);
    wr(1, 1); rd(1, "w1c_after");

    wr(0, 0); wr(2, 32'hFFFF_FFFE); wr(3, 32'h10); wr(1, 3); wr(0, 9);
    rd(2, "ovf_ff"); check("ovf_ff_const", HRDATA, 32'hFFFF_FFFF);
    rd(2, "ovf_0"); check("ovf_0_const", HRDATA, 0);
    rd(1, "ovf_status"); check("ovf_status_const", HRDATA, 2);

    wr(0, 0);
    b2b(3, 32'h1234); check("b2b_const", HRDATA, 32'h1234);
    rd(6, "rd_18");
    HSEL = 1; HTRANS = 0; HWRITE = 1; HADDR = 32'hC; step(0, 0, 0);
    HSEL = 0; HTRANS = 2; HWDATA = 32'hDEAD; step(0, 0, 0);
    HWRITE = 1; HADDR = 32'hC; HSEL = 0; HTRANS = 2; step(0, 0, 0);
    bus_idle(); HWDATA = 32'hBEEF; step(0, 0, 0);
    rd(3, "idle_wr"); check("idle_wr_const", HRDATA, 32'h1234);

`ifdef MFP_TIMER_PRESCALER_EN
    wr(4, 3); wr(2, 0); wr(0, 1);
    repeat (16) rd(2, "psc_count");
    rd(4, "psc_reg");
`else
    wr(4, 32'hFFFF); rd(4, "psc_absent"); check("psc_absent_const", HRDATA, 0);
`endif

    for (int i = 0; i < 400; i++) begin
      int op = $urandom_range(0, 9), a = $urandom_range(0, 7);
      if (op < 4) wr(a, rnd_data(a));
      else if (op < 7) rd(a, "rnd_rd");
      else if (op == 7) begin bus_idle(); step(0, 0, 0); end
      else if (op == 8) begin
        HSEL = 1'($urandom); HTRANS = HSEL ? 2'($urandom_range(0, 1)) : 2'($urandom);
        HWRITE = 1; HADDR = 32'(a << 2); step(0, 0, 0);
        bus_idle(); HWDATA = $urandom; step(0, 0, 0);
      end else b2b(a, rnd_data(a));
    end

    wr(1, 3); wr(2, 0); wr(3, 2); wr(0, 5);
    repeat (4) begin bus_idle(); step(0, 0, 0); end
    rd(2, "pre_reset");
    check("pre_reset_irq", {31'b0, TIMER_IRQ}, 1);
    #2 HRESETn = 0;
    #1;
    check("async_hrdata", HRDATA, 0);
    check("async_irq", {31'b0, TIMER_IRQ}, 0);
    #2 HRESETn = 1;
    m_reset();
    rd(2, "post_count"); check("post_count_const", HRDATA, 0);
    rd(0, "post_ctrl"); rd(3, "post_compare");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
